multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL provide parameter EN_JAL, default 1, meaning jal (opcode 110_1111) is decoded; when 0, jal is illegal.
REQ-002 SHALL provide parameter EN_UBR, default 1, meaning bltu/bgeu are decoded; when 0, funct3 110/111 branches are illegal.
REQ-003 SHALL provide parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 areset  input  1  reset; synchronous, active-high.
REQ-006 Instr  input  32  instruction register contents; opcode [6:0], funct3 [14:12], funct7 bit [30].
REQ-007 ZF, SF, CF  input  1 each  ALU zero, sign, and borrow flags of the current ALU operation.
REQ-008 MemReady  input  1  memory completes the current read or write this cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite, MemRead, AdrSrc  output  1 each  datapath strobes and selects.
REQ-010 ALUSrcA, ALUSrcB, ResultSrc  output  2 each  operand and result selects; ALUSrcA 00 PC, 01 OldPC, 10 rs1; ALUSrcB 00 rs2, 01 Imm, 10 const 4; ResultSrc 00 ALUOut, 01 Data, 10 ALUResult.
REQ-011 ImmSrc  output  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-012 ALUControl  output  3  ALU operation: 000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
REQ-013 IllegalInstr  output  1  sticky illegal-instruction flag.
REQ-014 InstrRet  output  CNT_W  count of retired instructions.
REQ-015 State  output  4  current FSM state, for debug.

Function
REQ-016 The FSM SHALL use these states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, TRAP 11.
REQ-017 All outputs SHALL be Moore-decoded from State, except PCWrite in BRANCH and the MemReady-qualified strobes; any output not listed for a state SHALL be 0.
REQ-018 FETCH SHALL drive: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10; IRWrite=PCWrite=MemReady; next state DECODE if MemReady, else FETCH.
REQ-019 DECODE SHALL drive: ALUSrcA=01, ALUSrcB=01, ImmSrc per opcode, ALUControl=000.
REQ-020 DECODE next state SHALL be: 000_0011/010_0011 -> MEMADR; 011_0011 -> EXECR; 001_0011 -> EXECI; 110_0011 -> BRANCH; 110_1111 -> JAL if EN_JAL; any other opcode -> TRAP.
REQ-021 MEMADR SHALL drive: ALUSrcA=10, ALUSrcB=01, ALUControl=000, and ImmSrc 00 (load) or 01 (store); next state MEMREAD (load) or MEMWRITE (store).
REQ-022 MEMREAD SHALL drive MemRead=1 and AdrSrc=1, and SHALL hold until MemReady, then go to MEMWB.
REQ-023 MEMWB SHALL drive ResultSrc=01 and RegWrite=1; next state FETCH.
REQ-024 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1, and SHALL hold until MemReady, then go to FETCH; MemWrite SHALL stay high while waiting.
REQ-025 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=00; both SHALL go to ALUWB.
REQ-026 In EXECR/EXECI, ALUControl SHALL decode funct3 as: 000 add, or sub when opcode[5]=1 and funct7=1; 001 sll; 100 xor; 101 srl; 110 or; 111 and; 010/011 add.
REQ-027 ALUWB SHALL drive ResultSrc=00 and RegWrite=1; next state FETCH.
REQ-028 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUControl=010, ResultSrc=00, and PCWrite=taken; next state FETCH.
REQ-029 Branch taken SHALL be: funct3 000 ZF; 001 ~ZF; 100 SF; 101 ~SF; 110 CF; 111 ~CF.
REQ-030 Branch funct3 010/011, and 110/111 with EN_UBR=0, SHALL go to TRAP with PCWrite=0.
REQ-031 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00, ImmSrc=11, and PCWrite=1; next state ALUWB.
REQ-032 TRAP SHALL set IllegalInstr=1, drive all strobes 0, and remain in TRAP until reset.
REQ-033 InstrRet SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, or BRANCH.

Reset
REQ-034 With areset=1 at a rising edge, the block SHALL set State=FETCH, IllegalInstr=0, and InstrRet=0, overriding any pending transition, including mid-wait in MEMREAD or MEMWRITE.
REQ-035 While areset=1, PCWrite, IRWrite, RegWrite, and MemWrite SHALL be forced to 0.

Verification
REQ-036 Reset, then MemReady held 0 for 3 cycles -> State stays 0 with MemRead=1 and IRWrite=0; MemReady=1 -> IRWrite=PCWrite=1, then State=1.
REQ-037 lw (0x00402083) with MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrRet=1.
REQ-038 sub (0x40208133) -> state 6 with ALUControl=010, then state 8 with RegWrite=1; add (0x00208133) -> ALUControl=000.
REQ-039 bltu (funct3 110) with CF=1 -> PCWrite=1 in state 9; with CF=0 -> PCWrite=0; with EN_UBR=0 -> State=11 and IllegalInstr=1.
REQ-040 sw with MemReady=0, then areset=1 mid-wait -> MemWrite=0 during reset, and State=0 and InstrRet=0 after the edge.
REQ-041 CNT_W=2, 5 retired addi -> InstrRet=1; opcode 0x7F -> State=11 and IllegalInstr sticky until reset.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit for a small RV32I-style datapath.
// A Moore FSM sequences fetch, decode, memory access, ALU execution,
// conditional branches and jal. It also keeps a sticky illegal-instruction
// flag and a wrapping count of retired instructions.
module multicycle_control_unit #(
  parameter bit EN_JAL = 1'b1,
  parameter bit EN_UBR = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [31:0]      Instr,
  input  logic             ZF,
  input  logic             SF,
  input  logic             CF,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             IllegalInstr,
  output logic [CNT_W-1:0] InstrRet,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_R      = 7'b011_0011;
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;

  state_t             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   instrRet_q, instrRet_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b;
  logic       unusedInstrBits;

  logic       pcWriteRaw, irWriteRaw, regWriteRaw, memWriteRaw;
  logic       branchTaken, branchLegal;
  logic [2:0] aluExec;
  logic       retire;

  assign opcode          = Instr[6:0];
  assign funct3          = Instr[14:12];
  assign funct7b         = Instr[30];
  assign unusedInstrBits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // Flag-based branch condition and legality of the branch funct3 encoding
  always_comb begin
    branchTaken = 1'b0;
    branchLegal = 1'b0;
    case (funct3)
      3'b000: begin branchTaken = ZF;  branchLegal = 1'b1;   end
      3'b001: begin branchTaken = ~ZF; branchLegal = 1'b1;   end
      3'b100: begin branchTaken = SF;  branchLegal = 1'b1;   end
      3'b101: begin branchTaken = ~SF; branchLegal = 1'b1;   end
      3'b110: begin branchTaken = CF;  branchLegal = EN_UBR; end
      3'b111: begin branchTaken = ~CF; branchLegal = EN_UBR; end
      default: begin branchTaken = 1'b0; branchLegal = 1'b0; end
    endcase
  end

  // ALU operation for register and immediate arithmetic; sub only exists in the register form
  always_comb begin
    aluExec = 3'b000;
    case (funct3)
      3'b000:  aluExec = (opcode[5] && funct7b) ? 3'b010 : 3'b000;
      3'b001:  aluExec = 3'b001;
      3'b100:  aluExec = 3'b100;
      3'b101:  aluExec = 3'b101;
      3'b110:  aluExec = 3'b110;
      3'b111:  aluExec = 3'b111;
      default: aluExec = 3'b000;
    endcase
  end

  // Next-state and Moore output decode; every output defaults to 0
  always_comb begin
    state_d     = state_q;
    pcWriteRaw  = 1'b0;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    MemRead     = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ImmSrc      = 2'b00;
    ALUControl  = 3'b000;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        irWriteRaw = MemReady;
        pcWriteRaw = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_STORE:  ImmSrc = 2'b01;
          OP_BRANCH: ImmSrc = 2'b10;
          OP_JAL:    ImmSrc = 2'b11;
          default:   ImmSrc = 2'b00;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_IMM:            state_d = S_EXECI;
          OP_BRANCH:         state_d = branchLegal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = EN_JAL ? S_JAL : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_STORE) begin
          ImmSrc  = 2'b01;
          state_d = S_MEMWRITE;
        end else begin
          ImmSrc  = 2'b00;
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        MemRead = 1'b1;
        AdrSrc  = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = aluExec;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = 2'b00;
        ALUControl = aluExec;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc   = 2'b00;
        regWriteRaw = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        ResultSrc  = 2'b00;
        pcWriteRaw = branchTaken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ALUControl = 3'b000;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b11;
        pcWriteRaw = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Retirement bookkeeping and the sticky trap flag
  always_comb begin
    retire = (state_d == S_FETCH) &&
             ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
              (state_q == S_ALUWB) || (state_q == S_BRANCH));
    instrRet_d = retire ? instrRet_q + {{(CNT_W-1){1'b0}}, 1'b1} : instrRet_q;
    illegal_d  = illegal_q | (state_d == S_TRAP);
  end

  // State, flag and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= S_FETCH;
      illegal_q  <= 1'b0;
      instrRet_q <= '0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      instrRet_q <= instrRet_d;
    end
  end

  assign PCWrite      = pcWriteRaw  & ~areset;
  assign IRWrite      = irWriteRaw  & ~areset;
  assign RegWrite     = regWriteRaw & ~areset;
  assign MemWrite     = memWriteRaw & ~areset;
  assign IllegalInstr = illegal_q;
  assign InstrRet     = instrRet_q;
  assign State        = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit.
// dut0 uses default parameters; dut1 disables jal and unsigned branches and
// uses a 2-bit retire counter. Both share the same stimulus.
module tb_multicycle_control_unit;

  localparam logic [31:0] LW   = 32'h00402083;
  localparam logic [31:0] SW   = 32'h00002023;
  localparam logic [31:0] SUB  = 32'h40208133;
  localparam logic [31:0] ADD  = 32'h00208133;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] BLTU = 32'h00006063;
  localparam logic [31:0] JAL  = 32'h0000006F;
  localparam logic [31:0] BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] Instr;
  logic        ZF, SF, CF, MemReady;

  logic        d0PCWrite, d0IRWrite, d0RegWrite, d0MemWrite, d0MemRead, d0AdrSrc;
  logic [1:0]  d0ALUSrcA, d0ALUSrcB, d0ResultSrc, d0ImmSrc;
  logic [2:0]  d0ALUControl;
  logic        d0Illegal;
  logic [15:0] d0InstrRet;
  logic [3:0]  d0State;

  logic        d1PCWrite, d1Illegal;
  logic [1:0]  d1InstrRet;
  logic [3:0]  d1State;
  logic        unusedD1IRWrite, unusedD1RegWrite, unusedD1MemWrite, unusedD1MemRead, unusedD1AdrSrc;
  logic [1:0]  unusedD1ALUSrcA, unusedD1ALUSrcB, unusedD1ResultSrc, unusedD1ImmSrc;
  logic [2:0]  unusedD1ALUControl;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  multicycle_control_unit dut0 (
    .clk(clk), .areset(areset), .Instr(Instr), .ZF(ZF), .SF(SF), .CF(CF), .MemReady(MemReady),
    .PCWrite(d0PCWrite), .IRWrite(d0IRWrite), .RegWrite(d0RegWrite), .MemWrite(d0MemWrite),
    .MemRead(d0MemRead), .AdrSrc(d0AdrSrc), .ALUSrcA(d0ALUSrcA), .ALUSrcB(d0ALUSrcB),
    .ResultSrc(d0ResultSrc), .ImmSrc(d0ImmSrc), .ALUControl(d0ALUControl),
    .IllegalInstr(d0Illegal), .InstrRet(d0InstrRet), .State(d0State)
  );

  multicycle_control_unit #(.EN_JAL(1'b0), .EN_UBR(1'b0), .CNT_W(2)) dut1 (
    .clk(clk), .areset(areset), .Instr(Instr), .ZF(ZF), .SF(SF), .CF(CF), .MemReady(MemReady),
    .PCWrite(d1PCWrite), .IRWrite(unusedD1IRWrite), .RegWrite(unusedD1RegWrite),
    .MemWrite(unusedD1MemWrite), .MemRead(unusedD1MemRead), .AdrSrc(unusedD1AdrSrc),
    .ALUSrcA(unusedD1ALUSrcA), .ALUSrcB(unusedD1ALUSrcB), .ResultSrc(unusedD1ResultSrc),
    .ImmSrc(unusedD1ImmSrc), .ALUControl(unusedD1ALUControl),
    .IllegalInstr(d1Illegal), .InstrRet(d1InstrRet), .State(d1State)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic rdy,
                               input logic z, input logic s, input logic c);
    areset   = rst;
    Instr    = ins;
    MemReady = rdy;
    ZF       = z;
    SF       = s;
    CF       = c;
    #1;
  endtask

  // Single comparison point with failure accounting
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    applyStimulus(1'b1, LW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rstState",    32'(d0State), 32'd0);
    checkOutput("rstInstrRet", 32'(d0InstrRet), 32'd0);
    checkOutput("rstIllegal",  32'(d0Illegal), 32'd0);
    checkOutput("rstIRWrite",  32'(d0IRWrite), 32'd0);
    checkOutput("rstPCWrite",  32'(d0PCWrite), 32'd0);

    applyStimulus(1'b0, LW, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fetchWaitState",   32'(d0State), 32'd0);
      checkOutput("fetchWaitMemRead", 32'(d0MemRead), 32'd1);
      checkOutput("fetchWaitIRWrite", 32'(d0IRWrite), 32'd0);
      tick();
    end
    applyStimulus(1'b0, LW, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("fetchIRWrite", 32'(d0IRWrite), 32'd1);
    checkOutput("fetchPCWrite", 32'(d0PCWrite), 32'd1);
    tick();
    checkOutput("lwDecodeState", 32'(d0State), 32'd1);
    checkOutput("lwDecodeSrcA",  32'(d0ALUSrcA), 32'd1);
    checkOutput("lwDecodeImm",   32'(d0ImmSrc), 32'd0);
    tick();
    checkOutput("lwMemAdrState", 32'(d0State), 32'd2);
    checkOutput("lwMemAdrSrcA",  32'(d0ALUSrcA), 32'd2);
    checkOutput("lwMemAdrRegWr", 32'(d0RegWrite), 32'd0);
    tick();
    checkOutput("lwMemReadState",  32'(d0State), 32'd3);
    checkOutput("lwMemReadAdrSrc", 32'(d0AdrSrc), 32'd1);
    checkOutput("lwMemReadRegWr",  32'(d0RegWrite), 32'd0);
    tick();
    checkOutput("lwMemWbState",  32'(d0State), 32'd4);
    checkOutput("lwMemWbRegWr",  32'(d0RegWrite), 32'd1);
    checkOutput("lwMemWbResult", 32'(d0ResultSrc), 32'd1);
    tick();
    checkOutput("lwDoneState",    32'(d0State), 32'd0);
    checkOutput("lwDoneRegWr",    32'(d0RegWrite), 32'd0);
    checkOutput("lwDoneInstrRet", 32'(d0InstrRet), 32'd1);

    applyStimulus(1'b0, SUB, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("subExecState", 32'(d0State), 32'd6);
    checkOutput("subAluCtl",    32'(d0ALUControl), 32'd2);
    checkOutput("subSrcB",      32'(d0ALUSrcB), 32'd0);
    tick();
    checkOutput("subWbState", 32'(d0State), 32'd8);
    checkOutput("subWbRegWr", 32'(d0RegWrite), 32'd1);
    tick();
    checkOutput("subInstrRet", 32'(d0InstrRet), 32'd2);

    applyStimulus(1'b0, ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("addAluCtl", 32'(d0ALUControl), 32'd0);
    tick();
    tick();
    checkOutput("addInstrRet",   32'(d0InstrRet), 32'd3);
    checkOutput("addInstrRetD1", 32'(d1InstrRet), 32'd3);

    applyStimulus(1'b0, BLTU, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("bltuTakenState",  32'(d0State), 32'd9);
    checkOutput("bltuTakenPCWr",   32'(d0PCWrite), 32'd1);
    checkOutput("bltuTakenAluCtl", 32'(d0ALUControl), 32'd2);
    checkOutput("bltuNoUbrState",  32'(d1State), 32'd11);
    checkOutput("bltuNoUbrIllegal", 32'(d1Illegal), 32'd1);
    checkOutput("bltuNoUbrPCWr",   32'(d1PCWrite), 32'd0);
    tick();
    checkOutput("bltuTakenInstrRet", 32'(d0InstrRet), 32'd4);

    applyStimulus(1'b0, BLTU, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("bltuNotTakenState", 32'(d0State), 32'd9);
    checkOutput("bltuNotTakenPCWr",  32'(d0PCWrite), 32'd0);
    tick();
    checkOutput("bltuNotTakenInstrRet", 32'(d0InstrRet), 32'd5);
    checkOutput("trapStickyD1",      32'(d1Illegal), 32'd1);
    checkOutput("trapStickyStateD1", 32'(d1State), 32'd11);

    applyStimulus(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst2InstrRet",  32'(d0InstrRet), 32'd0);
    checkOutput("rst2IllegalD1", 32'(d1Illegal), 32'd0);
    checkOutput("rst2StateD1",   32'(d1State), 32'd0);

    applyStimulus(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("addiExecState", 32'(d0State), 32'd7);
    checkOutput("addiSrcB",      32'(d0ALUSrcB), 32'd1);
    checkOutput("addiAluCtl",    32'(d0ALUControl), 32'd0);
    tick();
    tick();
    checkOutput("addiInstrRet", 32'(d0InstrRet), 32'd1);

    applyStimulus(1'b0, SW, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("swMemAdrImm", 32'(d0ImmSrc), 32'd1);
    applyStimulus(1'b0, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("swWaitState",  32'(d0State), 32'd5);
    checkOutput("swWaitMemWr",  32'(d0MemWrite), 32'd1);
    checkOutput("swWaitAdrSrc", 32'(d0AdrSrc), 32'd1);
    tick();
    checkOutput("swHoldState", 32'(d0State), 32'd5);
    checkOutput("swHoldMemWr", 32'(d0MemWrite), 32'd1);
    applyStimulus(1'b1, SW, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("swRstMemWr", 32'(d0MemWrite), 32'd0);
    tick();
    checkOutput("swRstState",    32'(d0State), 32'd0);
    checkOutput("swRstInstrRet", 32'(d0InstrRet), 32'd0);

    applyStimulus(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) tick();
    checkOutput("addi5State",      32'(d0State), 32'd0);
    checkOutput("addi5InstrRet",   32'(d0InstrRet), 32'd5);
    checkOutput("addi5InstrRetD1", 32'(d1InstrRet), 32'd1);

    applyStimulus(1'b0, JAL, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jalDecodeImm", 32'(d0ImmSrc), 32'd3);
    tick();
    checkOutput("jalState",     32'(d0State), 32'd10);
    checkOutput("jalPCWr",      32'(d0PCWrite), 32'd1);
    checkOutput("jalSrcA",      32'(d0ALUSrcA), 32'd1);
    checkOutput("jalSrcB",      32'(d0ALUSrcB), 32'd2);
    checkOutput("jalNoJalState", 32'(d1State), 32'd11);
    tick();
    checkOutput("jalWbState", 32'(d0State), 32'd8);
    tick();
    checkOutput("jalInstrRet", 32'(d0InstrRet), 32'd6);

    applyStimulus(1'b0, BAD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("badState",   32'(d0State), 32'd11);
    checkOutput("badIllegal", 32'(d0Illegal), 32'd1);
    checkOutput("badMemRead", 32'(d0MemRead), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("badHoldState",    32'(d0State), 32'd11);
    checkOutput("badHoldIllegal",  32'(d0Illegal), 32'd1);
    checkOutput("badHoldIRWrite",  32'(d0IRWrite), 32'd0);
    checkOutput("badHoldInstrRet", 32'(d0InstrRet), 32'd6);

    applyStimulus(1'b1, BAD, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rst3State",   32'(d0State), 32'd0);
    checkOutput("rst3Illegal", 32'(d0Illegal), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
